// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_adder
// Description : Bit-serial WIDTH-bit adder. One full-adder slice and a
//               registered carry are applied to the operands one bit per
//               clock, LSB first. A start/done handshake frames each
//               operation. The result is the same sum/carry a ripple chain of
//               WIDTH full adders would produce, at WIDTH+1 cycles of latency.
//
// Ports       : clk      - rising-edge clock
//               rst      - synchronous, active-high reset
//               i_start  - request; sampled only in IDLE or DONE
//               i_a      - operand A, captured on accepted start
//               i_b      - operand B, captured on accepted start
//               i_sub    - subtract select, captured on accepted start
//                          (only when BIT_SERIAL_ADDER_SUB_EN is defined)
//               o_busy   - high while bits are being processed
//               o_done   - one-cycle pulse, o_sum/o_carry just updated
//               o_sum    - result word, held until the next completion
//               o_carry  - carry out of the MSB, held with o_sum
//
// Options     : BIT_SERIAL_ADDER_SUB_EN - when defined, adds the i_sub port.
//               i_sub=1 computes a - b as a + ~b + 1; o_carry=1 then means
//               no borrow (a >= b). Undefined: add only.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Counter value while the final (MSB) bit is being processed.
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_a;      // operand A, shifted right each bit
    logic [WIDTH-1:0] r_b;      // operand B (inverted for subtract), shifted right
    logic             r_c;      // running carry between bit slices
    logic [WIDTH-2:0] r_res;    // upper result bits computed so far
    logic [CNT_W-1:0] r_cnt;    // index of the bit being processed

    // ------------------------------------------------------------------------
    // Load values: subtract inverts B and presets the carry, turning the
    // adder into a + ~b + 1.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_load_b;
    logic             w_load_c;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    assign w_load_b = i_sub ? ~i_b : i_b;
    assign w_load_c = i_sub;
`else
    assign w_load_b = i_b;
    assign w_load_c = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Single full-adder slice on the current LSBs
    // ------------------------------------------------------------------------
    logic             w_a0;
    logic             w_b0;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_accept;

    assign w_a0 = r_a[0];
    assign w_b0 = r_b[0];
    assign w_s  = w_a0 ^ w_b0 ^ r_c;
    assign w_c  = (w_a0 & w_b0) | (r_c & (w_a0 ^ w_b0));

    // New bit enters from the MSB side, so after WIDTH shifts the first
    // (LSB) bit has travelled down to bit 0. r_res only needs WIDTH-1 bits
    // because the newest bit is still combinational in w_s; the full word
    // is assembled here and written straight to o_sum on the final bit.
    assign w_res_next = {w_s, r_res};

    assign w_last = (r_cnt == c_LAST_BIT);

    // A new request is taken in IDLE and also in DONE, which gives
    // back-to-back operation at one op per WIDTH+1 cycles.
    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // ------------------------------------------------------------------------
    // Control FSM and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sum   <= '0;
            o_carry <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless the final bit sets it below.
            o_done <= 1'b0;

            if (w_accept) begin
                r_a     <= i_a;
                r_b     <= w_load_b;
                r_c     <= w_load_c;
                r_res   <= '0;
                r_cnt   <= '0;
                o_busy  <= 1'b1;
                r_state <= S_SHIFT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end

                    S_SHIFT: begin
                        // Operands shift right so the next bit sits at [0].
                        // i_start is ignored here; operands are not re-sampled.
                        r_a   <= r_a >> 1;
                        r_b   <= r_b >> 1;
                        r_c   <= w_c;
                        r_res <= w_res_next[WIDTH-1:1];
                        r_cnt <= r_cnt + c_CNT_ONE;

                        if (w_last) begin
                            // Outputs update only here, so they stay stable
                            // through any following operation.
                            o_sum   <= w_res_next;
                            o_carry <= w_c;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end

                    S_DONE: begin
                        r_state <= S_IDLE;
                    end

                    default: begin
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
